// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-4 stream demultiplexer:
//   NUM_CH      number of output channels
//   SEL_W       width of the channel select
//   state_e     packet-framing FSM state (IDLE / PKT)
//   sel_onehot  channel select -> one-hot channel enable
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_e;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One-entry output register with valid/ready handshake and a same-cycle
// refill path: a beat draining this cycle can be replaced by a new one.
//   clk, rst_n   clock, synchronous active-low reset
//   load_i       write data_i/last_i into the slot this cycle
//   data_i       payload to store
//   last_i       packet-end flag to store
//   ready_i      downstream consumer ready
//   valid_o      slot holds a beat
//   data_o       stored payload
//   last_o       stored packet-end flag
//   free_o       slot can take a beat this cycle (empty, or draining now)
// ---------------------------------------------------------------------------
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             free_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             last_q,  last_d;

    // NOTE: every signal gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            // Refill wins over drain: a beat leaving this cycle is replaced.
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: payload is reset too, because out_data must read zero
            // after reset, not just out_valid.
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/demux1_4_stream.sv
// ---------------------------------------------------------------------------
// demux1_4_stream
// Registered 1-to-4 stream demultiplexer with packet framing. The channel is
// taken from {s1,s2} on the first beat of a packet and held until the last
// beat is accepted. Each channel has its own one-entry output slot, so a
// stalled consumer only blocks the input, never the other channels.
//   clk, rst_n   clock, synchronous active-low reset
//   in_data      input payload
//   in_last      input beat ends the packet
//   in_valid     input beat present
//   in_ready     block accepts a beat this cycle
//   s1, s2       channel select (s1 = MSB)
//   out_data     channel k payload at [k*WIDTH +: WIDTH]
//   out_last     per-channel packet-end flag
//   out_valid    per-channel beat present
//   out_ready    per-channel consumer ready
//   busy         packet in progress, select locked
// ---------------------------------------------------------------------------
module demux1_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    s1,
    input  logic                    s2,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_last,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic                    busy
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  lk_q, lk_d;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  eff_ch;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] slot_free;
    logic              in_xfer;

    assign sel = {s1, s2};

    // State register and locked channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lk_q    <= '0;
        end else begin
            state_q <= state_d;
            lk_q    <= lk_d;
        end
    end

    // Next-state logic: lock on a non-final first beat, unlock on last.
    always_comb begin
        state_d = state_q;
        lk_d    = lk_q;
        case (state_q)
            IDLE: begin
                if (in_xfer && !in_last) begin
                    state_d = PKT;
                    lk_d    = sel;
                end
            end
            PKT: begin
                if (in_xfer && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: channel routing and handshake. in_ready depends only on
    // state and slot occupancy, never on in_valid.
    always_comb begin
        eff_ch   = (state_q == PKT) ? lk_q : sel;
        in_ready = rst_n && slot_free[eff_ch];
        in_xfer  = in_valid && in_ready;
        load     = in_xfer ? sel_onehot(eff_ch) : '0;
        busy     = (state_q == PKT);
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[k]),
            .data_i  (in_data),
            .last_i  (in_last),
            .ready_i (out_ready[k]),
            .valid_o (out_valid[k]),
            .data_o  (out_data[k*WIDTH +: WIDTH]),
            .last_o  (out_last[k]),
            .free_o  (slot_free[k])
        );
    end

endmodule

// File: tb/tb_demux1_4_stream.sv
// ---------------------------------------------------------------------------
// tb_demux1_4_stream
// Self-checking bench: a per-channel behavioural model is compared against
// the DUT on every falling edge, directed scenarios add literal checks, and
// a randomized phase exercises mixed traffic, back-pressure and resets.
// ---------------------------------------------------------------------------
module tb_demux1_4_stream;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           in_valid;
    logic           in_ready;
    logic           s1, s2;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_last;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic           busy;

    demux1_4_stream #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s1        (s1),
        .s2        (s2),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is a one-beat holding place; the packet owner is a plain
    // channel number remembered while a packet is open.
    logic [W-1:0] m_data  [4];
    bit           m_valid [4];
    bit           m_last  [4];
    bit           m_open;
    int           m_owner;
    bit           cmp_en = 1'b0;
    int           m_dest;
    bit           m_take;

    function automatic int target();
        return m_open ? m_owner : int'({s1, s2});
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_valid[k] = 1'b0;
                m_last[k]  = 1'b0;
                m_data[k]  = '0;
            end
            m_open  = 1'b0;
            m_owner = 0;
        end else begin
            m_dest = target();
            m_take = in_valid && (!m_valid[m_dest] || out_ready[m_dest]);
            for (int k = 0; k < 4; k++)
                if (out_ready[k]) m_valid[k] = 1'b0;
            if (m_take) begin
                m_valid[m_dest] = 1'b1;
                m_data[m_dest]  = in_data;
                m_last[m_dest]  = in_last;
                if (!m_open && !in_last) begin
                    m_open  = 1'b1;
                    m_owner = m_dest;
                end else if (m_open && in_last) begin
                    m_open = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0]   ev, el;
            logic [4*W-1:0] ed;
            int           t;
            for (int k = 0; k < 4; k++) begin
                ev[k]          = m_valid[k];
                el[k]          = m_last[k];
                ed[k*W +: W]   = m_data[k];
            end
            t = target();
            check("cyc_out_valid", out_valid, ev);
            check("cyc_out_last",  out_last,  el);
            check("cyc_out_data",  out_data,  ed);
            check("cyc_busy",      busy,      m_open);
            check("cyc_in_ready",  in_ready,  rst_n && (!m_valid[t] || out_ready[t]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [W-1:0] d, input logic l);
        {s1, s2} = sel;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        in_last   = 1'b0;
        {s1, s2}  = 2'b00;
        out_ready = 4'hF;

        // Reset held two cycles with in_valid asserted.
        tick();
        cmp_en = 1'b1;
        check("rst_valid",    out_valid, 4'b0000);
        check("rst_in_ready", in_ready,  1'b0);
        check("rst_busy",     busy,      1'b0);
        tick();
        check("rst2_valid",   out_valid, 4'b0000);
        check("rst2_data",    out_data,  32'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1'b1);

        // Single-beat routing on every channel.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] d;
            d = W'((i + 1) * 8'h11);
            send(2'(i), d, 1'b1);
            check("route_valid", out_valid, 32'(1 << i));
            check("route_data",  out_data[i*W +: W], d);
            check("route_last",  out_last[i], 1'b1);
        end
        tick();

        // Select lock: sel changes mid-packet are ignored.
        send(2'b10, 8'hA0, 1'b0);
        check("lock_b0_valid", out_valid, 4'b0100);
        check("lock_b0_data",  out_data[2*W +: W], 8'hA0);
        check("lock_b0_busy",  busy, 1'b1);
        send(2'b01, 8'hA1, 1'b0);
        check("lock_b1_valid", out_valid, 4'b0100);
        check("lock_b1_data",  out_data[2*W +: W], 8'hA1);
        check("lock_b1_busy",  busy, 1'b1);
        send(2'b01, 8'hA2, 1'b1);
        check("lock_b2_valid", out_valid, 4'b0100);
        check("lock_b2_data",  out_data[2*W +: W], 8'hA2);
        check("lock_b2_busy",  busy, 1'b0);
        send(2'b01, 8'hB0, 1'b1);
        check("lock_next_valid", out_valid, 4'b0010);
        check("lock_next_data",  out_data[1*W +: W], 8'hB0);
        tick();

        // Back-pressure on ch3 with same-cycle drain and refill.
        out_ready = 4'b0111;
        send(2'b11, 8'h55, 1'b1);
        check("bp_hold_valid", out_valid, 4'b1000);
        check("bp_hold_data",  out_data[3*W +: W], 8'h55);
        in_data  = 8'h66;
        in_valid = 1'b1;
        #1;
        check("bp_in_ready_lo", in_ready, 1'b0);
        tick();
        check("bp_still_55", out_data[3*W +: W], 8'h55);
        out_ready = 4'hF;
        #1;
        check("bp_in_ready_hi", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_refill_valid", out_valid, 4'b1000);
        check("bp_refill_data",  out_data[3*W +: W], 8'h66);
        tick();
        check("bp_drained", out_valid, 4'b0000);

        // Independent drain: ch0 stalled, ch1 flows.
        out_ready = 4'b1110;
        send(2'b00, 8'h77, 1'b1);
        out_ready = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            send(2'b01, W'(8'hC0 + j), 1'(j == 2));
            check("ind_valid",  out_valid, 4'b0011);
            check("ind_ch1",    out_data[1*W +: W], W'(8'hC0 + j));
            check("ind_ch0",    out_data[0 +: W], 8'h77);
        end
        out_ready = 4'hF;
        tick();
        check("ind_empty", out_valid, 4'b0000);

        // Reset in the middle of a packet.
        send(2'b10, 8'hD0, 1'b0);
        send(2'b10, 8'hD1, 1'b0);
        check("mid_busy", busy, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hD2;
        tick();
        in_valid = 1'b0;
        check("mid_rst_valid", out_valid, 4'b0000);
        check("mid_rst_busy",  busy, 1'b0);
        rst_n = 1'b1;
        send(2'b00, 8'hE0, 1'b0);
        check("post_valid", out_valid, 4'b0001);
        check("post_data",  out_data[0 +: W], 8'hE0);
        check("post_busy",  busy, 1'b1);
        send(2'b11, 8'hE1, 1'b1);
        check("post_last_valid", out_valid, 4'b0001);
        check("post_last_busy",  busy, 1'b0);

        // Randomized traffic with back-pressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 3) == 0);
            in_data   = W'($urandom);
            {s1, s2}  = 2'($urandom_range(0, 3));
            out_ready = 4'($urandom);
            tick();
        end

        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
